generator_impulsow_na_stopien: RTL

Consumer end of the ticks-per-degree interface: takes `taktowanie_na_stopien` (clock cycles per degree of shaft rotation) and produces a one-cycle pulse per degree. It also keeps a modulo-360 angle register and a once-per-revolution pulse. It sits directly downstream of `obliczanie_taktowania_na_stopien` in the engine-driver datapath and feeds the phase/commutation logic.

---
 rtl/pkg_naped.sv | 13 +
 rtl/licznik_kata.sv | 54 +++++
 rtl/generator_impulsow_na_stopien.sv | 86 ++++++++
 3 files changed

// File: rtl/pkg_naped.sv
// Shared constants and FSM state type for the engine-driver angle datapath.
package pkg_naped;

  localparam int unsigned LICZBA_STOPNI  = 360;
  localparam int unsigned SZEROKOSC_TAKT = 9;
  localparam int unsigned SZEROKOSC_KAT  = 9;

  typedef enum logic [0:0] {
    StStop,
    StRun
  } stan_e;

endpackage

// File: rtl/licznik_kata.sv
// Up/down modulo-Liczba angle counter with a registered wrap pulse.
module licznik_kata #(
  parameter int unsigned Liczba    = 360,
  parameter int unsigned Szerokosc = 9
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en_i,
  input  logic                 kierunek_i,
  output logic [Szerokosc-1:0] kat_o,
  output logic                 obrot_o
);

  localparam logic [Szerokosc-1:0] KatMax = Szerokosc'(Liczba - 1);

  logic [Szerokosc-1:0] kat_d, kat_q;
  logic                 obrot_d, obrot_q;

  always_comb begin
    kat_d   = kat_q;
    obrot_d = 1'b0;
    if (en_i) begin
      if (kierunek_i) begin
        if (kat_q == KatMax) begin
          kat_d   = '0;
          obrot_d = 1'b1;
        end else begin
          kat_d = kat_q + Szerokosc'(1);
        end
      end else begin
        if (kat_q == '0) begin
          kat_d   = KatMax;
          obrot_d = 1'b1;
        end else begin
          kat_d = kat_q - Szerokosc'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kat_q   <= '0;
      obrot_q <= 1'b0;
    end else begin
      kat_q   <= kat_d;
      obrot_q <= obrot_d;
    end
  end

  assign kat_o   = kat_q;
  assign obrot_o = obrot_q;

endmodule

// File: rtl/generator_impulsow_na_stopien.sv
// Turns a ticks-per-degree period into one pulse per degree plus a modulo-360 angle.
module generator_impulsow_na_stopien
  import pkg_naped::*;
#(
  parameter int unsigned SZEROKOSC_TAKT = pkg_naped::SZEROKOSC_TAKT,
  parameter int unsigned LICZBA_STOPNI  = pkg_naped::LICZBA_STOPNI
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [SZEROKOSC_TAKT-1:0] taktowanie_na_stopien,
  input  logic                      kierunek,
  output logic                      impuls_stopnia,
  output logic [SZEROKOSC_KAT-1:0]  kat,
  output logic                      obrot,
  output logic                      ruch
);

  localparam logic [SZEROKOSC_TAKT-1:0] Jeden = SZEROKOSC_TAKT'(1);

  stan_e                     stan_q;
  logic [SZEROKOSC_TAKT-1:0] licznik_q;
  logic [SZEROKOSC_TAKT-1:0] okres_q;
  logic                      kierunek_q;
  logic                      impuls_q;
  logic                      ruch_q;
  logic                      granica;

  // okres_q is never zero while running, so P-1 cannot underflow here.
  assign granica = (stan_q == StRun) && (licznik_q == okres_q - Jeden);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stan_q     <= StStop;
      licznik_q  <= '0;
      okres_q    <= '0;
      kierunek_q <= 1'b1;
      impuls_q   <= 1'b0;
      ruch_q     <= 1'b0;
    end else begin
      impuls_q <= 1'b0;
      unique case (stan_q)
        StStop: begin
          licznik_q <= '0;
          if (taktowanie_na_stopien != '0) begin
            okres_q    <= taktowanie_na_stopien;
            kierunek_q <= kierunek;
            stan_q     <= StRun;
            ruch_q     <= 1'b1;
          end
        end
        StRun: begin
          if (granica) begin
            licznik_q  <= '0;
            impuls_q   <= 1'b1;
            kierunek_q <= kierunek;
            if (taktowanie_na_stopien == '0) begin
              stan_q <= StStop;
              ruch_q <= 1'b0;
            end else begin
              okres_q <= taktowanie_na_stopien;
            end
          end else begin
            licznik_q <= licznik_q + Jeden;
          end
        end
      endcase
    end
  end

  // The angle steps with the direction latched for the degree now completing.
  licznik_kata #(
    .Liczba   (LICZBA_STOPNI),
    .Szerokosc(SZEROKOSC_KAT)
  ) u_licznik_kata (
    .clk       (clk),
    .rst_n     (rst_n),
    .en_i      (granica),
    .kierunek_i(kierunek_q),
    .kat_o     (kat),
    .obrot_o   (obrot)
  );

  assign impuls_stopnia = impuls_q;
  assign ruch           = ruch_q;

endmodule
